soc_arbiter_ahb3: RTL



---
 rtl/soc_arbiter_ahb3_if.sv | 53 +++++
 rtl/soc_arbiter_ahb3.sv | 119 +++++++++++
 2 files changed

// File: rtl/soc_arbiter_ahb3_if.sv
// Bus bundle between AHB3-Lite masters, the soc_arbiter_ahb3 arbiter and the downstream decoder.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface soc_arbiter_ahb3_if #(
  parameter int MASTERS = 2,
  parameter int XLEN    = 32,
  parameter int PLEN    = 32
);
  localparam int SW = XLEN >> 3;

  logic [MASTERS-1:0]           m_hsel_i;
  logic [MASTERS-1:0][PLEN-1:0] m_haddr_i;
  logic [MASTERS-1:0][XLEN-1:0] m_hwdata_i;
  logic [MASTERS-1:0][XLEN-1:0] m_hrdata_o;
  logic [MASTERS-1:0]           m_hwrite_i;
  logic [MASTERS-1:0][2:0]      m_hsize_i;
  logic [MASTERS-1:0][2:0]      m_hburst_i;
  logic [MASTERS-1:0][SW-1:0]   m_hprot_i;
  logic [MASTERS-1:0][1:0]      m_htrans_i;
  logic [MASTERS-1:0]           m_hmastlock_i;
  logic [MASTERS-1:0]           m_hready_o;
  logic [MASTERS-1:0]           m_hresp_o;

  logic            s_hsel_o;
  logic [PLEN-1:0] s_haddr_o;
  logic [XLEN-1:0] s_hwdata_o;
  logic [XLEN-1:0] s_hrdata_i;
  logic            s_hwrite_o;
  logic [2:0]      s_hsize_o;
  logic [2:0]      s_hburst_o;
  logic [SW-1:0]   s_hprot_o;
  logic [1:0]      s_htrans_o;
  logic            s_hmastlock_o;
  logic            s_hready_i;
  logic            s_hresp_i;

  modport slave (
    input  m_hsel_i, m_haddr_i, m_hwdata_i, m_hwrite_i, m_hsize_i, m_hburst_i,
           m_hprot_i, m_htrans_i, m_hmastlock_i,
    output m_hrdata_o, m_hready_o, m_hresp_o,
    output s_hsel_o, s_haddr_o, s_hwdata_o, s_hwrite_o, s_hsize_o, s_hburst_o,
           s_hprot_o, s_htrans_o, s_hmastlock_o,
    input  s_hrdata_i, s_hready_i, s_hresp_i
  );

  modport master (
    output m_hsel_i, m_haddr_i, m_hwdata_i, m_hwrite_i, m_hsize_i, m_hburst_i,
           m_hprot_i, m_htrans_i, m_hmastlock_i,
    input  m_hrdata_o, m_hready_o, m_hresp_o,
    input  s_hsel_o, s_haddr_o, s_hwdata_o, s_hwrite_o, s_hsize_o, s_hburst_o,
           s_hprot_o, s_htrans_o, s_hmastlock_o,
    output s_hrdata_i, s_hready_i, s_hresp_i
  );
endinterface

// File: rtl/soc_arbiter_ahb3.sv
// Multi-master AHB3-Lite arbiter feeding the address decoder; holds grant across bursts and locks.
// Define SOC_ARB_AHB3_RR_EN for round-robin arbitration, otherwise fixed lowest-index priority.
module soc_arbiter_ahb3 #(
  parameter int MASTERS = 2,
  parameter int XLEN    = 32,
  parameter int PLEN    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  soc_arbiter_ahb3_if.slave   bus
);
  localparam int SW = XLEN >> 3;
  localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      dp_owner_q, dp_owner_d;
  logic               dp_valid_q, dp_valid_d;
  logic [GW-1:0]      nxt_grant;
  logic [MASTERS-1:0] req, others;
  logic               rel;
  logic [MASTERS-1:0] hready_v, hresp_v;

  logic [PLEN-1:0] haddr_g;
  logic [XLEN-1:0] hwdata_g;
  logic [SW-1:0]   hprot_g;

  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERS; i++) begin
      req[i] = bus.m_hsel_i[i] & bus.m_htrans_i[i][1];
    end
    others = req;
    others[grant_q] = 1'b0;
    rel = (~bus.m_hsel_i[grant_q] | (bus.m_htrans_i[grant_q] == HTRANS_IDLE))
          & ~bus.m_hmastlock_i[grant_q];
  end

`ifdef SOC_ARB_AHB3_RR_EN
  // Scan downward so the closest requester after the current grant wins.
  always_comb begin
    logic [GW-1:0] cand;
    cand      = '0;
    nxt_grant = grant_q;
    for (int k = MASTERS - 1; k >= 1; k--) begin
      cand = GW'((int'(grant_q) + k) % MASTERS);
      if (others[cand]) nxt_grant = cand;
    end
  end
`else
  always_comb begin
    nxt_grant = grant_q;
    for (int k = MASTERS - 1; k >= 0; k--) begin
      if (others[k]) nxt_grant = GW'(k);
    end
  end
`endif

  always_comb begin
    grant_d    = grant_q;
    dp_owner_d = dp_owner_q;
    dp_valid_d = dp_valid_q;
    if (bus.s_hready_i) begin
      if (rel && (|others)) grant_d = nxt_grant;
      dp_owner_d = grant_q;
      dp_valid_d = req[grant_q];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q    <= '0;
      dp_owner_q <= '0;
      dp_valid_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      dp_owner_q <= dp_owner_d;
      dp_valid_q <= dp_valid_d;
    end
  end

  assign haddr_g  = bus.m_haddr_i[grant_q];
  assign hwdata_g = bus.m_hwdata_i[grant_q];
  assign hprot_g  = bus.m_hprot_i[grant_q];

  // Reset only needs to silence the qualifying fields; grant_q is 0 so the rest follow master 0.
  assign bus.s_hsel_o      = bus.m_hsel_i[grant_q] & ~rst_i;
  assign bus.s_htrans_o    = rst_i ? HTRANS_IDLE : bus.m_htrans_i[grant_q];
  assign bus.s_hmastlock_o = bus.m_hmastlock_i[grant_q] & ~rst_i;
  assign bus.s_haddr_o     = haddr_g;
  assign bus.s_hwdata_o    = hwdata_g;
  assign bus.s_hprot_o     = hprot_g;
  assign bus.s_hwrite_o    = bus.m_hwrite_i[grant_q];
  assign bus.s_hsize_o     = bus.m_hsize_i[grant_q];
  assign bus.s_hburst_o    = bus.m_hburst_i[grant_q];

  always_comb begin
    logic own;
    own      = 1'b0;
    hready_v = '0;
    hresp_v  = '0;
    for (int i = 0; i < MASTERS; i++) begin
      own = dp_valid_q && (dp_owner_q == GW'(i));
      if (rst_i) begin
        hready_v[i] = 1'b0;
      end else if ((grant_q == GW'(i)) || own) begin
        hready_v[i] = bus.s_hready_i;
      end else begin
        hready_v[i] = ~req[i];
      end
      hresp_v[i] = ~rst_i & own & bus.s_hresp_i;
    end
  end

  assign bus.m_hready_o = hready_v;
  assign bus.m_hresp_o  = hresp_v;
  assign bus.m_hrdata_o = {MASTERS{bus.s_hrdata_i}};

endmodule
